mem_stage_np: RTL and testbench

- Parametrised load/store execute stage; successor to the fixed two-lane word-only memory stage.
- Accepts NUM_LANES memory micro-ops per cycle from the memory issue queue, in program order: lane 0 oldest.
- Supports byte/half/word loads and stores with sign/zero extension, per-byte store-to-load forwarding between same-cycle lanes, misalignment flagging, and active-list recall squash.
- Backed by a byte-enable, multi-port synchronous RAM; results go to writeback one cycle after issue.

---
 rtl/mem_stage_np_pkg.sv | 71 +++++++
 rtl/mem_stage_np_bram.sv | 43 ++++
 rtl/mem_stage_np.sv | 180 ++++++++++++++++++
 tb/tb_mem_stage_np.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_np_pkg.sv
// -----------------------------------------------------------------------------
// mem_stage_np_pkg
// Shared definitions for the load/store execute stage: the memory micro-op
// encoding, physical-register width, and the size / byte-enable / store-data
// replication / load-extraction helpers used by the stage.
// No ports (package).
// -----------------------------------------------------------------------------
package mem_stage_np_pkg;

   localparam int PREG_W = 6;

   typedef enum logic [2:0] {
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW
   } mem_op_t;

   typedef enum logic [1:0] {
      SZ_BYTE, SZ_HALF, SZ_WORD
   } mem_size_t;

   function automatic mem_size_t size_of(input mem_op_t op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
         OP_LH, OP_LHU, OP_SH: return SZ_HALF;
         default:              return SZ_WORD;
      endcase
   endfunction

   function automatic logic is_store(input mem_op_t op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] ea_lo);
      case (size_of(op))
         SZ_HALF: return ea_lo[0];
         SZ_WORD: return (ea_lo != 2'b00);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] be_of(input mem_op_t op, input logic [1:0] ea_lo);
      case (size_of(op))
         SZ_BYTE: return 4'b0001 << ea_lo;
         SZ_HALF: return ea_lo[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // Store data copied into every byte lane it could occupy; the byte
   // enables then pick the lanes actually written.
   function automatic logic [31:0] repl_of(input mem_op_t op, input logic [31:0] data);
      case (size_of(op))
         SZ_BYTE: return {4{data[7:0]}};
         SZ_HALF: return {2{data[15:0]}};
         default: return data;
      endcase
   endfunction

   function automatic logic [31:0] extract(input mem_op_t op, input logic [31:0] word,
                                           input logic [1:0] ea_lo);
      logic [31:0] sh;
      sh = word >> {ea_lo, 3'b000};
      case (op)
         OP_LB:   return {{24{sh[7]}}, sh[7:0]};
         OP_LBU:  return {24'd0, sh[7:0]};
         OP_LH:   return {{16{sh[15]}}, sh[15:0]};
         OP_LHU:  return {16'd0, sh[15:0]};
         default: return word;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_np_bram.sv
// -----------------------------------------------------------------------------
// bram_be_block
// Multi-port 32-bit-word RAM with per-byte write enables and synchronous,
// read-before-write reads. When several ports write the same byte in one
// cycle, the highest-numbered port wins. Contents are not reset.
// Ports:
//   clk    clock
//   we     per-port write enable
//   be     per-port 4-bit byte enable
//   addr   per-port word address
//   wdata  per-port write data (already placed in its byte lanes)
//   rdata  per-port read data, registered (contents before this cycle's writes)
// -----------------------------------------------------------------------------
module bram_be_block
   import mem_stage_np_pkg::*;
#(
   parameter  int NUM_PORTS = 2,
   parameter  int DEPTH     = 1024,
   localparam int IDX_W     = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic [NUM_PORTS-1:0] we,
   input  logic [3:0]           be    [NUM_PORTS],
   input  logic [IDX_W-1:0]     addr  [NUM_PORTS],
   input  logic [31:0]          wdata [NUM_PORTS],
   output logic [31:0]          rdata [NUM_PORTS]
);

   logic [31:0] mem [DEPTH];

   // Later ports' non-blocking writes override earlier ones on a shared byte.
   always_ff @(posedge clk) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         rdata[p] <= mem[addr[p]];
         for (int b = 0; b < 4; b++) begin
            if (we[p] && be[p][b]) begin
               mem[addr[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/mem_stage_np.sv
// -----------------------------------------------------------------------------
// mem_stage_np
// Parametrised load/store execute stage. NUM_LANES micro-ops per cycle in
// program order (lane 0 oldest); byte/half/word loads and stores, same-cycle
// store-to-load forwarding from older lanes, misalignment flagging and
// active-list recall squash. Results reach writeback one cycle after issue.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   if_recall                  squash request this cycle
//   new_front, old_front       squash range [new_front, old_front), circular
//   back                       active-list head (not used by the datapath)
//   i_valid/i_op/i_base/i_imm  issued micro-op, effective address = base+imm
//   i_wdata, i_rd, i_al_idx    store data, destination, active-list index
//   o_valid, o_data, o_rd      writeback valid, load result, destination
//   o_uses_rd                  valid aligned load writes o_rd
//   o_al_idx, o_misalign       active-list index, misaligned-access flag
// -----------------------------------------------------------------------------
module mem_stage_np
   import mem_stage_np_pkg::*;
#(
   parameter  int NUM_LANES  = 2,
   parameter  int DEPTH      = 1024,
   parameter  int ADDR_WIDTH = 32,
   parameter  int AL_SIZE    = 8,
   localparam int AL_W       = $clog2(AL_SIZE)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  if_recall,
   input  logic [AL_W-1:0]       new_front,
   input  logic [AL_W-1:0]       old_front,
   input  logic [AL_W-1:0]       back,
   input  logic [NUM_LANES-1:0]  i_valid,
   input  mem_op_t               i_op     [NUM_LANES],
   input  logic [31:0]           i_base   [NUM_LANES],
   input  logic [31:0]           i_imm    [NUM_LANES],
   input  logic [31:0]           i_wdata  [NUM_LANES],
   input  logic [PREG_W-1:0]     i_rd     [NUM_LANES],
   input  logic [AL_W-1:0]       i_al_idx [NUM_LANES],
   output logic [NUM_LANES-1:0]  o_valid,
   output logic [31:0]           o_data   [NUM_LANES],
   output logic [PREG_W-1:0]     o_rd     [NUM_LANES],
   output logic [NUM_LANES-1:0]  o_uses_rd,
   output logic [AL_W-1:0]       o_al_idx [NUM_LANES],
   output logic [NUM_LANES-1:0]  o_misalign
);

   localparam int IDX_W = $clog2(DEPTH);

   // Circular membership in [nf, of); nf == of is an empty range.
   function automatic logic in_squash(input logic [AL_W-1:0] idx,
                                      input logic [AL_W-1:0] nf,
                                      input logic [AL_W-1:0] of);
      if (nf <= of) return (idx >= nf) && (idx < of);
      else          return (idx >= nf) || (idx < of);
   endfunction

   logic [ADDR_WIDTH-1:0] ea_c    [NUM_LANES];
   logic [IDX_W-1:0]      widx_c  [NUM_LANES];
   logic [1:0]            ealo_c  [NUM_LANES];
   logic [3:0]            be_c    [NUM_LANES];
   logic [31:0]           wrep_c  [NUM_LANES];
   logic [3:0]            fmask_c [NUM_LANES];
   logic [31:0]           fdata_c [NUM_LANES];
   logic [31:0]           rdata   [NUM_LANES];
   logic [NUM_LANES-1:0]  live_c, mis_c, st_c, we_c;
   logic                  addr_unused;

   always_comb begin
      addr_unused = ^back;
      for (int l = 0; l < NUM_LANES; l++) begin
         ea_c[l]   = ADDR_WIDTH'(i_base[l] + i_imm[l]);
         widx_c[l] = ea_c[l][2+IDX_W-1:2];
         ealo_c[l] = ea_c[l][1:0];
         live_c[l] = i_valid[l] && !(if_recall && in_squash(i_al_idx[l], new_front, old_front));
         mis_c[l]  = is_misaligned(i_op[l], ealo_c[l]);
         st_c[l]   = is_store(i_op[l]);
         we_c[l]   = live_c[l] && st_c[l] && !mis_c[l];
         be_c[l]   = be_of(i_op[l], ealo_c[l]);
         wrep_c[l] = repl_of(i_op[l], i_wdata[l]);
         addr_unused = addr_unused ^ (^ea_c[l][ADDR_WIDTH-1:2+IDX_W]);
      end
   end

   // Per byte, the youngest older lane storing to the same word supplies it.
   for (genvar j = 0; j < NUM_LANES; j++) begin : g_fwd
      logic [3:0]  m;
      logic [31:0] d;
      always_comb begin
         m = '0;
         d = '0;
         for (int i = 0; i < j; i++) begin
            for (int b = 0; b < 4; b++) begin
               if (we_c[i] && (widx_c[i] == widx_c[j]) && be_c[i][b]) begin
                  m[b]         = 1'b1;
                  d[b*8 +: 8]  = wrep_c[i][b*8 +: 8];
               end
            end
         end
      end
      assign fmask_c[j] = m;
      assign fdata_c[j] = d;
   end

   bram_be_block #(
      .NUM_PORTS (NUM_LANES),
      .DEPTH     (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (we_c),
      .be    (be_c),
      .addr  (widx_c),
      .wdata (wrep_c),
      .rdata (rdata)
   );

   // ---- stage boundary: issue (p0) -> writeback (p1) ----
   logic [NUM_LANES-1:0] vld_p1, uses_p1, mis_p1;
   logic [PREG_W-1:0]    rd_p1    [NUM_LANES];
   logic [AL_W-1:0]      al_p1    [NUM_LANES];
   logic [3:0]           fmask_p1 [NUM_LANES];
   mem_op_t              op_p1    [NUM_LANES];
   logic [1:0]           ealo_p1  [NUM_LANES];
   logic [31:0]          fdata_p1 [NUM_LANES];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p1  <= '0;
         uses_p1 <= '0;
         mis_p1  <= '0;
         for (int l = 0; l < NUM_LANES; l++) begin
            rd_p1[l]    <= '0;
            al_p1[l]    <= '0;
            fmask_p1[l] <= '0;
         end
      end else begin
         for (int l = 0; l < NUM_LANES; l++) begin
            if (live_c[l]) begin
               vld_p1[l]   <= 1'b1;
               mis_p1[l]   <= mis_c[l];
               uses_p1[l]  <= !st_c[l] && !mis_c[l];
               rd_p1[l]    <= st_c[l] ? '0 : i_rd[l];
               al_p1[l]    <= i_al_idx[l];
               fmask_p1[l] <= fmask_c[l];
            end else begin
               vld_p1[l]   <= 1'b0;
               uses_p1[l]  <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int l = 0; l < NUM_LANES; l++) begin
         if (live_c[l]) begin
            op_p1[l]    <= i_op[l];
            ealo_p1[l]  <= ealo_c[l];
            fdata_p1[l] <= fdata_c[l];
         end
      end
   end

   // Forwarded bytes override the RAM word before extraction.
   always_comb begin
      for (int l = 0; l < NUM_LANES; l++) begin
         logic [31:0] merged;
         for (int b = 0; b < 4; b++) begin
            merged[b*8 +: 8] = fmask_p1[l][b] ? fdata_p1[l][b*8 +: 8] : rdata[l][b*8 +: 8];
         end
         o_data[l]   = uses_p1[l] ? extract(op_p1[l], merged, ealo_p1[l]) : 32'd0;
         o_rd[l]     = rd_p1[l];
         o_al_idx[l] = al_p1[l];
      end
   end

   assign o_valid    = vld_p1;
   assign o_uses_rd  = uses_p1;
   assign o_misalign = mis_p1;

endmodule

// File: tb/tb_mem_stage_np.sv
module tb_mem_stage_np;
   import mem_stage_np_pkg::*;

   localparam int NL   = 2;
   localparam int AL_W = 3;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              if_recall = 1'b0;
   logic [AL_W-1:0]   new_front = '0, old_front = '0, back = '0;
   logic [NL-1:0]     i_valid = '0;
   mem_op_t           i_op     [NL];
   logic [31:0]       i_base   [NL];
   logic [31:0]       i_imm    [NL];
   logic [31:0]       i_wdata  [NL];
   logic [PREG_W-1:0] i_rd     [NL];
   logic [AL_W-1:0]   i_al_idx [NL];
   logic [NL-1:0]     o_valid, o_uses_rd, o_misalign;
   logic [31:0]       o_data   [NL];
   logic [PREG_W-1:0] o_rd     [NL];
   logic [AL_W-1:0]   o_al_idx [NL];

   int n_cmp = 0;
   int n_bad = 0;

   mem_stage_np #(
      .NUM_LANES (NL), .DEPTH (1024), .ADDR_WIDTH (32), .AL_SIZE (8)
   ) dut (
      .clk (clk), .reset (reset), .if_recall (if_recall),
      .new_front (new_front), .old_front (old_front), .back (back),
      .i_valid (i_valid), .i_op (i_op), .i_base (i_base), .i_imm (i_imm),
      .i_wdata (i_wdata), .i_rd (i_rd), .i_al_idx (i_al_idx),
      .o_valid (o_valid), .o_data (o_data), .o_rd (o_rd),
      .o_uses_rd (o_uses_rd), .o_al_idx (o_al_idx), .o_misalign (o_misalign)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic lane(input int l, input mem_op_t op, input logic [31:0] base,
                       input logic [31:0] imm, input logic [31:0] wdata,
                       input logic [PREG_W-1:0] rd, input logic [AL_W-1:0] al);
      i_valid[l]  = 1'b1;
      i_op[l]     = op;
      i_base[l]   = base;
      i_imm[l]    = imm;
      i_wdata[l]  = wdata;
      i_rd[l]     = rd;
      i_al_idx[l] = al;
   endtask

   task automatic idle();
      i_valid = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int l = 0; l < NL; l++) begin
         i_op[l] = OP_LB; i_base[l] = '0; i_imm[l] = '0;
         i_wdata[l] = '0; i_rd[l] = '0; i_al_idx[l] = '0;
      end
      tick(); tick();
      chk("rst_valid",    32'(o_valid),    32'd0);
      chk("rst_uses",     32'(o_uses_rd),  32'd0);
      chk("rst_misalign", 32'(o_misalign), 32'd0);
      chk("rst_rd0",      32'(o_rd[0]),    32'd0);
      chk("rst_al1",      32'(o_al_idx[1]),32'd0);
      chk("rst_data0",    o_data[0],       32'd0);
      reset = 1'b0;

      // Store then load back one cycle later.
      lane(0, OP_SW, 32'h100, 32'h0, 32'hDEADBEEF, 6'd5, 3'd1);
      tick();
      chk("sw_valid0", 32'(o_valid[0]),   32'd1);
      chk("sw_valid1", 32'(o_valid[1]),   32'd0);
      chk("sw_uses0",  32'(o_uses_rd[0]), 32'd0);
      chk("sw_rd0",    32'(o_rd[0]),      32'd0);
      chk("sw_data0",  o_data[0],         32'd0);
      idle();
      lane(0, OP_LW, 32'h100, 32'h0, 32'h0, 6'd7, 3'd2);
      tick();
      chk("lw_data0", o_data[0],         32'hDEADBEEF);
      chk("lw_uses0", 32'(o_uses_rd[0]), 32'd1);
      chk("lw_rd0",   32'(o_rd[0]),      32'd7);
      chk("lw_al0",   32'(o_al_idx[0]),  32'd2);

      // Same-cycle forward of one byte from an older store.
      idle();
      lane(0, OP_SW, 32'h100, 32'h0, 32'h11223344, 6'd0, 3'd3);
      tick();
      idle();
      lane(0, OP_SB, 32'h100, 32'h1, 32'h0000007F, 6'd0, 3'd4);
      lane(1, OP_LW, 32'h100, 32'h0, 32'h0, 6'd9, 3'd5);
      tick();
      chk("fwd_data1", o_data[1],        32'h11227F44);
      chk("fwd_rd1",   32'(o_rd[1]),     32'd9);
      idle();
      lane(0, OP_LW, 32'h100, 32'h0, 32'h0, 6'd1, 3'd6);
      tick();
      chk("sb_ram_data0", o_data[0], 32'h11227F44);

      // Younger store does not forward to an older load.
      idle();
      lane(0, OP_SW, 32'h200, 32'h0, 32'h12345678, 6'd0, 3'd0);
      tick();
      idle();
      lane(0, OP_LW, 32'h200, 32'h0, 32'h0, 6'd2, 3'd1);
      lane(1, OP_SW, 32'h200, 32'h0, 32'hAAAAAAAA, 6'd0, 3'd2);
      tick();
      chk("nofwd_data0", o_data[0], 32'h12345678);
      idle();
      lane(0, OP_LW, 32'h200, 32'h0, 32'h0, 6'd2, 3'd3);
      tick();
      chk("young_ram_data0", o_data[0], 32'hAAAAAAAA);

      // Two stores to one word: youngest lane wins its byte.
      idle();
      lane(0, OP_SW, 32'h300, 32'h0, 32'h11111111, 6'd0, 3'd4);
      lane(1, OP_SB, 32'h300, 32'h2, 32'h00000022, 6'd0, 3'd5);
      tick();
      idle();
      lane(0, OP_LW, 32'h300, 32'h0, 32'h0, 6'd3, 3'd6);
      tick();
      chk("wins_data0", o_data[0], 32'h11221111);

      // Extension and misalignment.
      idle();
      lane(0, OP_SW, 32'hF0, 32'h10, 32'h80000000, 6'd0, 3'd7);
      tick();
      idle();
      lane(0, OP_LB,  32'h100, 32'h3, 32'h0, 6'd4, 3'd0);
      lane(1, OP_LBU, 32'h100, 32'h3, 32'h0, 6'd5, 3'd1);
      tick();
      chk("lb_data0",  o_data[0], 32'hFFFFFF80);
      chk("lbu_data1", o_data[1], 32'h00000080);
      idle();
      lane(0, OP_LH,  32'h102, 32'h0, 32'h0, 6'd4, 3'd2);
      lane(1, OP_LHU, 32'h102, 32'h0, 32'h0, 6'd5, 3'd3);
      tick();
      chk("lh_data0",  o_data[0], 32'hFFFF8000);
      chk("lhu_data1", o_data[1], 32'h00008000);
      idle();
      lane(0, OP_LH, 32'h100, 32'h1, 32'h0, 6'd6, 3'd4);
      lane(1, OP_SH, 32'h100, 32'h1, 32'h0000BEEF, 6'd0, 3'd5);
      tick();
      chk("mis_valid0", 32'(o_valid[0]),    32'd1);
      chk("mis_flag0",  32'(o_misalign[0]), 32'd1);
      chk("mis_uses0",  32'(o_uses_rd[0]),  32'd0);
      chk("mis_data0",  o_data[0],          32'd0);
      chk("mis_flag1",  32'(o_misalign[1]), 32'd1);
      idle();
      lane(0, OP_LW, 32'h1100, 32'h0, 32'h0, 6'd8, 3'd6);
      tick();
      chk("mis_nowrite_wrap", o_data[0], 32'h80000000);
      chk("aligned_flag0", 32'(o_misalign[0]), 32'd0);

      // Recall squash with a wrapped range [5, 2).
      idle();
      lane(0, OP_SW, 32'h400, 32'h0, 32'h01020304, 6'd0, 3'd0);
      tick();
      idle();
      if_recall = 1'b1; new_front = 3'd5; old_front = 3'd2;
      lane(0, OP_SW, 32'h400, 32'h0, 32'h55555555, 6'd0, 3'd6);
      lane(1, OP_SW, 32'h404, 32'h0, 32'h66666666, 6'd0, 3'd3);
      tick();
      chk("sq_valid0", 32'(o_valid[0]), 32'd0);
      chk("sq_valid1", 32'(o_valid[1]), 32'd1);
      idle();
      if_recall = 1'b0;
      lane(0, OP_LW, 32'h400, 32'h0, 32'h0, 6'd1, 3'd1);
      lane(1, OP_LW, 32'h404, 32'h0, 32'h0, 6'd2, 3'd2);
      tick();
      chk("sq_ram0", o_data[0], 32'h01020304);
      chk("sq_ram1", o_data[1], 32'h66666666);
      idle();
      if_recall = 1'b1; new_front = 3'd4; old_front = 3'd4;
      lane(0, OP_SW, 32'h408, 32'h0, 32'h77777777, 6'd0, 3'd4);
      tick();
      chk("sq_empty_valid0", 32'(o_valid[0]), 32'd1);
      idle();
      if_recall = 1'b0;

      // Asynchronous reset clears outputs before the next edge.
      lane(0, OP_LW, 32'h408, 32'h0, 32'h0, 6'd3, 3'd5);
      tick();
      chk("pre_rst_valid0", 32'(o_valid[0]), 32'd1);
      chk("pre_rst_data0",  o_data[0],       32'h77777777);
      reset = 1'b1;
      #1;
      chk("async_rst_valid", 32'(o_valid),   32'd0);
      chk("async_rst_uses",  32'(o_uses_rd), 32'd0);
      chk("async_rst_rd0",   32'(o_rd[0]),   32'd0);
      idle();
      tick();
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
